// File: rtl/life_engine.sv
// life_engine
//   Parametrised Conway Game-of-Life core (B3/S23). Holds a ROWS x COLS grid,
//   evolves it under run-time control (hold / load / free-run / single-step),
//   counts generations and flags stable and extinct grids. A free-run can
//   optionally halt by itself on the first evolution that leaves the grid unchanged.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous reset, active-low
//   grid_in    in   load pattern, cell (r,c) = bit r*COLS+c
//   mode       in   00 HOLD, 01 LOAD, 10 RUN, 11 STEP
//   wrap       in   1 = toroidal neighbourhood, 0 = out-of-grid neighbours dead
//   grid_out   out  current generation (registered)
//   gen_count  out  evolutions since load/reset, saturating
//   stable     out  last evolution produced no change
//   extinct    out  grid_out is all zero
//   busy       out  free-running
module life_engine #(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int GEN_W     = 16,
   parameter int AUTO_HALT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ROWS*COLS-1:0] grid_in,
   input  logic [1:0]           mode,
   input  logic                 wrap,
   output logic [ROWS*COLS-1:0] grid_out,
   output logic [GEN_W-1:0]     gen_count,
   output logic                 stable,
   output logic                 extinct,
   output logic                 busy
);

   localparam int N = ROWS * COLS;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [1:0] M_HOLD = 2'b00;
   localparam logic [1:0] M_LOAD = 2'b01;
   localparam logic [1:0] M_RUN  = 2'b10;
   localparam logic [1:0] M_STEP = 2'b11;

   state_t           r_state;
   state_t           w_state_d;
   logic [N-1:0]     r_grid;
   logic [N-1:0]     w_grid_d;
   logic [GEN_W-1:0] r_gen;
   logic [GEN_W-1:0] w_gen_d;
   logic             r_stable;
   logic             w_stable_d;
   logic [1:0]       r_mode_q;

   logic [N-1:0]     w_next;
   logic             w_same;
   logic             w_step;
   logic [GEN_W-1:0] w_gen_inc;

   // Next-generation logic. Neighbour indices are resolved at elaboration:
   // each neighbour reads its wrapped cell, and cells that lie outside the
   // grid are additionally gated by wrap.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [8:0] w_nb;
         logic [3:0] w_sum;
         for (genvar k = 0; k < 9; k++) begin : g_nb
            localparam int DR  = k / 3 - 1;
            localparam int DC  = k % 3 - 1;
            localparam int RR  = r + DR;
            localparam int CC  = c + DC;
            localparam bit OUT = (RR < 0) || (RR >= ROWS) || (CC < 0) || (CC >= COLS);
            localparam int IDX = ((RR + ROWS) % ROWS) * COLS + ((CC + COLS) % COLS);
            if (k == 4) begin : g_self
               assign w_nb[k] = 1'b0;
            end else if (OUT) begin : g_edge
               assign w_nb[k] = wrap & r_grid[IDX];
            end else begin : g_in
               assign w_nb[k] = r_grid[IDX];
            end
         end
         assign w_sum = 4'($countones(w_nb));
         assign w_next[r*COLS+c] = (w_sum == 4'd3) | (r_grid[r*COLS+c] & (w_sum == 4'd2));
      end
   end

   assign w_same    = (w_next == r_grid);
   assign w_step    = (mode == M_STEP) && (r_mode_q != M_STEP);
   assign w_gen_inc = (&r_gen) ? r_gen : r_gen + GEN_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_grid   <= '0;
         r_gen    <= '0;
         r_stable <= 1'b0;
         r_mode_q <= M_HOLD;
      end else begin
         r_state  <= w_state_d;
         r_grid   <= w_grid_d;
         r_gen    <= w_gen_d;
         r_stable <= w_stable_d;
         r_mode_q <= mode;
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_grid_d   = r_grid;
      w_gen_d    = r_gen;
      w_stable_d = r_stable;
      unique case (mode)
         M_LOAD: begin
            w_grid_d   = grid_in;
            w_gen_d    = '0;
            w_stable_d = 1'b0;
            w_state_d  = S_IDLE;
         end
         M_HOLD: begin
            w_state_d = S_IDLE;
         end
         M_RUN: begin
            if (r_state == S_HALT) begin
               w_state_d = S_HALT;
            end else if ((AUTO_HALT != 0) && w_same) begin
               // halting edge: grid and counter are left untouched
               w_state_d  = S_HALT;
               w_stable_d = 1'b1;
            end else begin
               w_grid_d   = w_next;
               w_stable_d = w_same;
               w_gen_d    = w_gen_inc;
               w_state_d  = S_RUN;
            end
         end
         M_STEP: begin
            if (w_step) begin
               w_grid_d   = w_next;
               w_stable_d = w_same;
               w_gen_d    = w_gen_inc;
            end
            w_state_d = S_IDLE;
         end
         default: w_state_d = S_IDLE;
      endcase
   end

   assign grid_out  = r_grid;
   assign gen_count = r_gen;
   assign stable    = r_stable;
   assign extinct   = (r_grid == '0);
   assign busy      = (r_state == S_RUN);

endmodule
